// File: rtl/brc_iter.sv
// Iterative RISC-V branch comparator: walks the operands CHUNK bits per cycle from the MSB
// down and stops at the first differing chunk, so the latency depends on the data.
module brc_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic [2:0]       i_funct3,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_br_equal,
  output logic             o_br_less,
  output logic             o_taken,
  output logic             o_illegal
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MsbMask = WIDTH'(1) << (WIDTH - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("brc_iter: CHUNK must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       funct3_q;
  logic [KW-1:0]    k_q;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_eq, chunk_lt;

  assign a_chunk  = a_q[k_q*CHUNK +: CHUNK];
  assign b_chunk  = b_q[k_q*CHUNK +: CHUNK];
  assign chunk_eq = (a_chunk == b_chunk);
  assign chunk_lt = (a_chunk < b_chunk);
  assign o_ready  = (state_q == StIdle);

  function automatic logic taken_of(input logic [2:0] f, input logic eq, input logic lt);
    case (f)
      3'b000:          taken_of = eq;
      3'b001:          taken_of = ~eq;
      3'b100, 3'b110:  taken_of = lt;
      3'b101, 3'b111:  taken_of = ~lt;
      default:         taken_of = 1'b0;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      k_q        <= '0;
      o_valid    <= 1'b0;
      o_br_equal <= 1'b0;
      o_br_less  <= 1'b0;
      o_taken    <= 1'b0;
      o_illegal  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_valid && !i_flush) begin
            // Flipping the sign bits turns a signed compare into an unsigned one.
            a_q      <= i_funct3[1] ? i_rs1_data : (i_rs1_data ^ MsbMask);
            b_q      <= i_funct3[1] ? i_rs2_data : (i_rs2_data ^ MsbMask);
            funct3_q <= i_funct3;
            k_q      <= KW'(NCHUNK - 1);
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          if (i_flush) begin
            state_q <= StIdle;
          end else if (!chunk_eq || k_q == '0) begin
            // With k_q == 0 and equal chunks this yields equal = 1, less = 0.
            o_br_equal <= chunk_eq;
            o_br_less  <= chunk_lt;
            o_taken    <= taken_of(funct3_q, chunk_eq, chunk_lt);
            o_illegal  <= (funct3_q[2:1] == 2'b01);
            o_valid    <= 1'b1;
            state_q    <= StDone;
          end else begin
            k_q <= k_q - KW'(1);
          end
        end
        StDone: begin
          if (i_flush || i_ready) begin
            o_valid <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/brc_iter.md
BRC_ITER -- requirements
Module: brc_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits compared per cycle; WIDTH % CHUNK == 0 and CHUNK >= 1 (elaboration error otherwise); NCHUNK = WIDTH/CHUNK.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  clock; all state updates on rising edge.
REQ-005 i_reset  input  1  synchronous active-high reset.
REQ-006 i_flush  input  1  abort the in-flight compare, discard its result.
REQ-007 i_valid  input  1  request valid.
REQ-008 o_ready  output  1  block can accept a request.
REQ-009 i_rs1_data  input  WIDTH  operand A.
REQ-010 i_rs2_data  input  WIDTH  operand B.
REQ-011 i_funct3  input  3  RISC-V branch code: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-012 o_valid  output  1  result valid.
REQ-013 i_ready  input  1  consumer accepts the result.
REQ-014 o_br_equal  output  1  A == B.
REQ-015 o_br_less  output  1  A < B (signed unless funct3[1] = 1).
REQ-016 o_taken  output  1  branch condition true for the latched funct3.
REQ-017 o_illegal  output  1  latched funct3 was 010 or 011.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, DONE; o_ready = 1 only in IDLE.
REQ-019 Accept on rising edge where i_valid & o_ready & ~i_flush: latch operands and funct3, set chunk index k = NCHUNK-1, go BUSY.
REQ-020 Signed mode (funct3[1] = 0): MSB of both latched operands SHALL be inverted at latch time, so all chunk compares are unsigned.
REQ-021 Each BUSY cycle compares chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of A and B.
REQ-022 Chunks differ: o_br_equal = 0, o_br_less = (A chunk < B chunk unsigned); go DONE.
REQ-023 Chunks equal and k = 0: o_br_equal = 1, o_br_less = 0; go DONE.
REQ-024 Chunks equal and k > 0: k decrements; stay BUSY.
REQ-025 Latency: if the first differing chunk is p chunks below the top (p = 0 for the top chunk), o_valid SHALL rise p+1 edges after the accept edge; equal operands take NCHUNK edges.
REQ-026 o_taken: BEQ = eq, BNE = ~eq, BLT/BLTU = less, BGE/BGEU = ~less; for funct3 010/011, o_taken = 0 and o_illegal = 1, compare still performed.
REQ-027 In DONE, o_valid = 1 and all result outputs stay stable until o_valid & i_ready; on that edge go IDLE (o_ready = 1 next cycle).
REQ-028 o_valid = 0 in IDLE and BUSY; result outputs hold their last value outside DONE.
REQ-029 i_flush in BUSY or DONE: next state IDLE, o_valid = 0, no result delivered; i_flush in IDLE blocks acceptance that cycle.
REQ-030 CHUNK = WIDTH: single BUSY cycle, latency fixed at 1 edge.
REQ-031 Chunk index register width SHALL be max(1, $clog2(NCHUNK)).

Reset
REQ-032 i_reset has priority over i_flush and handshakes.
REQ-033 On the reset edge: state IDLE, k = 0, o_valid = 0, o_br_equal = 0, o_br_less = 0, o_taken = 0, o_illegal = 0; o_ready = 1 the following cycle.
REQ-034 Reset in BUSY or DONE SHALL abandon the operation with no o_valid pulse.

Verification
REQ-035 Defaults; BLT, A = 0x80000000, B = 0x00000001 -> o_valid 1 edge after accept, less = 1, equal = 0, taken = 1.
REQ-036 BLTU, same operands -> o_valid after 1 edge, less = 0, taken = 0.
REQ-037 BEQ, A = B = 0x12345678 -> o_valid after 4 edges, equal = 1, taken = 1; BNE same operands -> taken = 0.
REQ-038 BGE, A = 0x00000105, B = 0x00000106 -> differ at p = 3, o_valid after 4 edges, less = 1, taken = 0; hold i_ready = 0 for 3 cycles -> outputs stable, o_ready = 0.
REQ-039 funct3 = 010 -> o_illegal = 1, taken = 0; i_flush during BUSY -> no o_valid, o_ready = 1 next cycle.
REQ-040 i_reset in BUSY -> o_valid never asserts, all outputs 0; random regression at CHUNK in {1, 4, 32} against a reference signed/unsigned compare.
